freq_divider_bank: RTL and testbench
====================================

Name: freq_divider_bank

Overview:
- Parametrised successor to the fixed 100 MHz-to-1 Hz divider.
- Generates NUM_CH independent divided clocks from clk_100MHz.
- Each channel has a runtime-programmable divisor (glitch-free reload at period boundary), an enable, a one-cycle tick strobe and an exposed phase counter.
- Feeds the 7-segment refresh/multiplex logic and the seconds counter.

Parameters:
- NUM_CH, 4: number of divider channels (1..8).
- WIDTH, 27: counter/divisor width per channel.
- DEFAULT_DIV, 100000000: divisor loaded on reset (1 Hz from 100 MHz); must be >= 2 and fit in WIDTH.

Ports:
- clk_100MHz  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  NUM_CH  per-channel run enable
- load  input  NUM_CH  per-channel divisor load strobe, one cycle
- div_in  input  NUM_CH*WIDTH  per-channel divisor; channel c uses bits [c*WIDTH +: WIDTH]
- sync_clr  input  1  phase-align strobe; clears all channel counters together
- clk_out  output  NUM_CH  divided square clock per channel (registered)
- tick  output  NUM_CH  one-cycle pulse per completed period (registered)
- pending  output  NUM_CH  new divisor latched, not yet applied
- counter  output  NUM_CH*WIDTH  current phase count per channel

Behaviour:
- Reset (async, rst_n low) applies to all channels:
  - cnt=0, clk_out=0, tick=0, pending=0.
  - div_act=DEFAULT_DIV, div_shadow=DEFAULT_DIV.
- Divisor legality: a loaded value of 0 or 1 is clamped to 2 when latched into div_shadow.
- Counting (en=1, sync_clr=0):
  - cnt increments by 1 each cycle.
  - When cnt==div_act-1, the next cnt is 0 (wrap).
  - Period = div_act cycles.
- clk_out:
  - Low for cnt < (div_act>>1), high otherwise, with no glitches.
  - The registered flop is driven from the next-state compare, so clk_out always equals (cnt >= div_act>>1) for the current cnt.
  - Example: div 5 gives 2 cycles low, 3 high.
- tick:
  - Registered; high for exactly one cycle, the cycle in which cnt==0 as a result of a wrap.
  - Not asserted after enable start or sync_clr.
- Enable:
  - en=0: cnt held at 0, clk_out=0, tick=0 on the next edge.
  - en 0->1: counting starts from 0; first tick after div_act cycles.
- Load:
  - load[c]=1 latches the clamped div_in slice into div_shadow and sets pending.
  - div_shadow is copied to div_act, and pending cleared, on the wrap edge, or on the next edge if en=0.
  - Load coincident with a wrap: the new value is latched only and applies at the following wrap. No same-edge bypass.
  - Repeated loads before application: last one wins.
- sync_clr:
  - All enabled channels set cnt=0 and clk_out=0, with no tick.
  - Highest priority over wrap; a pending divisor is applied on the same edge.
- Shrinking the divisor cannot strand the counter, because div_act changes only at wrap or while cnt=0.
- Channels are fully independent apart from sync_clr.
- Widths: all comparisons are unsigned WIDTH-bit; div_act-1 never underflows because div_act >= 2.

Decomposition:
- Shared package/header:
  - Channel slice macro/function (c*WIDTH +: WIDTH).
  - MIN_DIV=2 constant.
  - Clamp function for divisor legality.
- One sub-module, freq_div_channel, containing the single-channel counter, shadow/active divisor, clk_out/tick flops and pending.
- Top level is a generate loop over NUM_CH, plus fan-out of sync_clr.

Test Plan (NUM_CH=2, WIDTH=8, DEFAULT_DIV=10):
- Reset release, en=2'b11 -> both channels: clk_out 5 low/5 high, tick every 10 cycles, counter 0..9 repeating.
- Ch0 load div_in=4 at cnt=3 -> pending=1; current period finishes at 10; following periods are 4 cycles (2 low/2 high); pending clears on the wrap edge.
- Ch1 load 0, then load 1 -> clamped to 2: clk_out toggles every cycle, tick every 2nd cycle; load 7 coincident with the wrap edge -> applied one period later (2 low/... 3 low/4 high thereafter).
- en[0] dropped mid-period at cnt=6 -> next edge cnt=0, clk_out=0, no tick; load 3 while disabled -> div_act=3 next edge; re-enable -> first tick 3 cycles later.
- Channels running with different phases, sync_clr pulse -> both counters 0 on the same edge, no tick, then ticks aligned per divisor.
- rst_n asserted asynchronously mid-period (between edges) -> outputs clear immediately, div_act=10, pending=0; after release, normal 10-cycle operation resumes.

Source files
------------

// File: rtl/freq_divider_bank_pkg.sv
// Shared constants and helpers for the divider bank.
// Slice indexing, minimum divisor and divisor clamping.
package freq_divider_bank_pkg;

  localparam int unsigned MIN_DIV = 2;
  localparam int unsigned MAX_W   = 32;

  // Low bit of channel c inside a packed c*w vector.
  function automatic int unsigned slice_lo(
    input int unsigned c,
    input int unsigned w
  );
    return c * w;
  endfunction

  // Divisors of 0 or 1 cannot produce a period; force them to 2.
  function automatic logic [MAX_W-1:0] clamp_div(
    input logic [MAX_W-1:0] d
  );
    return (d < MAX_W'(MIN_DIV)) ? MAX_W'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: phase counter, shadow/active divisor,
// registered clk_o and tick_o, pending flag. WIDTH <= 32.
module freq_div_channel
  import freq_divider_bank_pkg::*;
#(
  parameter int unsigned WIDTH       = 27,
  parameter int unsigned DEFAULT_DIV = 100000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             sync_clr_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pending_o,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             wrap;
  logic             bound;

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    sh_d   = sh_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    wrap   = en_i && (cnt_q == (act_q - ONE));
    bound  = 1'b0;

    if (!en_i) begin
      cnt_d = '0;
      bound = 1'b1;
    end else if (sync_clr_i) begin
      cnt_d = '0;
      bound = 1'b1;
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      bound  = 1'b1;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    // Apply the old shadow first; a same-edge load only
    // refills the shadow and waits for the next boundary.
    if (bound && pend_q) begin
      act_d  = sh_q;
      pend_d = 1'b0;
    end

    if (load_i) begin
      sh_d   = WIDTH'(clamp_div(MAX_W'(div_i)));
      pend_d = 1'b1;
    end

    // Compare on next-state values so clk_o tracks cnt_o
    // even on the edge where the divisor changes.
    clk_d = (cnt_d >= (act_d >> 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      act_q  <= DEF;
      sh_q   <= DEF;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      sh_q   <= sh_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign clk_o     = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/freq_divider_bank.sv
// Bank of NUM_CH independent programmable clock dividers
// sharing clk_100MHz, rst_n and a common sync_clr strobe.
module freq_divider_bank
  import freq_divider_bank_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WIDTH       = 27,
  parameter int unsigned DEFAULT_DIV = 100000000
) (
  input  logic                    clk_100MHz,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] div_in,
  input  logic                    sync_clr,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending,
  output logic [NUM_CH*WIDTH-1:0] counter
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    freq_div_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i      (clk_100MHz),
      .rst_ni     (rst_n),
      .en_i       (en[c]),
      .load_i     (load[c]),
      .div_i      (div_in[slice_lo(c, WIDTH) +: WIDTH]),
      .sync_clr_i (sync_clr),
      .clk_o      (clk_out[c]),
      .tick_o     (tick[c]),
      .pending_o  (pending[c]),
      .cnt_o      (counter[slice_lo(c, WIDTH) +: WIDTH])
    );
  end

endmodule

// File: tb/tb_freq_divider_bank.sv
// Randomized + directed bench for freq_divider_bank
// against a period/phase reference model.
module tb_freq_divider_bank;

  localparam int N   = 2;
  localparam int W   = 8;
  localparam int DEF = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   en;
  logic [N-1:0]   load;
  logic [N*W-1:0] div_in;
  logic           sync_clr;
  logic [N-1:0]   clk_out;
  logic [N-1:0]   tick;
  logic [N-1:0]   pending;
  logic [N*W-1:0] counter;

  always #5 clk = ~clk;

  freq_divider_bank #(
    .NUM_CH      (N),
    .WIDTH       (W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .div_in     (div_in),
    .sync_clr   (sync_clr),
    .clk_out    (clk_out),
    .tick       (tick),
    .pending    (pending),
    .counter    (counter)
  );

  int total = 0;
  int bad   = 0;

  int m_ph  [N];
  int m_per [N];
  int m_nxt [N];
  bit m_pend[N];
  bit m_tick[N];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_ph[c]   = 0;
      m_per[c]  = DEF;
      m_nxt[c]  = DEF;
      m_pend[c] = 0;
      m_tick[c] = 0;
    end
  endtask

  // Period-level view: phase walks 0..period-1; a new
  // period length takes effect at a period boundary.
  task automatic model_step(
    input logic [N-1:0]   e,
    input logic [N-1:0]   l,
    input logic [N*W-1:0] d,
    input logic           s
  );
    for (int c = 0; c < N; c++) begin
      bit bnd;
      int v;
      v   = int'(d[c*W +: W]);
      bnd = 1;
      m_tick[c] = 0;
      if (!e[c] || s) begin
        m_ph[c] = 0;
      end else if (m_ph[c] + 1 == m_per[c]) begin
        m_ph[c]   = 0;
        m_tick[c] = 1;
      end else begin
        m_ph[c] = m_ph[c] + 1;
        bnd     = 0;
      end
      if (bnd && m_pend[c]) begin
        m_per[c]  = m_nxt[c];
        m_pend[c] = 0;
      end
      if (l[c]) begin
        m_nxt[c]  = (v < 2) ? 2 : v;
        m_pend[c] = 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < N; c++) begin
      check($sformatf("cnt%0d", c),
            32'(counter[c*W +: W]), m_ph[c]);
      check($sformatf("clk%0d", c), 32'(clk_out[c]),
            (m_ph[c] >= m_per[c] / 2) ? 1 : 0);
      check($sformatf("tick%0d", c), 32'(tick[c]),
            32'(m_tick[c]));
      check($sformatf("pend%0d", c), 32'(pending[c]),
            32'(m_pend[c]));
    end
  endtask

  task automatic run_cycle(
    input logic [N-1:0]   e,
    input logic [N-1:0]   l,
    input logic [N*W-1:0] d,
    input logic           s
  );
    en       = e;
    load     = l;
    div_in   = d;
    sync_clr = s;
    @(posedge clk);
    model_step(e, l, d, s);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) run_cycle(2'b11, 2'b00, '0, 1'b0);
  endtask

  task automatic wait_ph(input int ch, input int ph);
    for (int k = 0; k < 300 && m_ph[ch] != ph; k++)
      idle(1);
    check($sformatf("wait%0d", ch),
          32'(m_ph[ch] == ph), 1);
  endtask

  initial begin
    logic [N-1:0]   re;
    logic [N-1:0]   rl;
    logic [N*W-1:0] rd;
    logic           rs;

    rst_n    = 1'b0;
    en       = '0;
    load     = '0;
    div_in   = '0;
    sync_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    idle(25);

    wait_ph(0, 3);
    run_cycle(2'b11, 2'b01, {8'd0, 8'd4}, 1'b0);
    idle(20);

    run_cycle(2'b11, 2'b10, {8'd0, 8'd0}, 1'b0);
    run_cycle(2'b11, 2'b10, {8'd1, 8'd0}, 1'b0);
    idle(12);
    wait_ph(1, m_per[1] - 1);
    run_cycle(2'b11, 2'b10, {8'd7, 8'd0}, 1'b0);
    idle(20);

    run_cycle(2'b11, 2'b01, {8'd0, 8'd10}, 1'b0);
    idle(12);
    wait_ph(0, 6);
    run_cycle(2'b10, 2'b00, '0, 1'b0);
    run_cycle(2'b10, 2'b01, {8'd0, 8'd3}, 1'b0);
    run_cycle(2'b10, 2'b00, '0, 1'b0);
    idle(10);

    idle(5);
    run_cycle(2'b11, 2'b00, '0, 1'b1);
    idle(20);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(25);

    repeat (3000) begin
      re = ($urandom_range(0, 15) == 0) ?
           N'($urandom) : 2'b11;
      rl = '0;
      rd = '0;
      for (int c = 0; c < N; c++) begin
        rl[c] = ($urandom_range(0, 15) == 0);
        rd[c*W +: W] = ($urandom_range(0, 31) == 0) ?
                       W'($urandom) :
                       W'($urandom_range(0, 12));
      end
      rs = ($urandom_range(0, 39) == 0);
      run_cycle(re, rl, rd, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
